// File: rtl/reg_file_seq.sv
// reg_file_seq: parametrised 2-read/1-write register file with a sequenced
// initialiser (stream preload over valid/ready, or clear one entry per cycle)
// and optional same-cycle write-to-read forwarding.
module reg_file_seq #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3,
   parameter int BYPASS = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [6:0]        start_address,
   input  logic              write,
   input  logic              dest,
   input  logic [ADDR_W-1:0] src1,
   input  logic [ADDR_W-1:0] src2,
   input  logic [DATA_W-1:0] writeData,
   input  logic [DATA_W-1:0] init_data,
   input  logic              init_valid,
   output logic              init_ready,
   output logic              busy,
   output logic              init_done,
   output logic              write_dropped,
   output logic [DATA_W-1:0] readData1,
   output logic [DATA_W-1:0] readData2
);

   localparam int DEPTH = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_CLEAR = 2'd2;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              done_q, done_d;
   logic              dropped_q, dropped_d;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [DATA_W-1:0] wdata;
   logic [ADDR_W-1:0] wr_idx;
   logic              busy_w;
   logic              last_ptr;
   logic              fwd1, fwd2;

   assign wr_idx   = dest ? src2 : src1;
   assign busy_w   = (state_q != S_IDLE);
   assign last_ptr = (ptr_q == ADDR_W'(DEPTH - 1));

   // Next-state and single write-port arbitration between user writes and the initialiser
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      done_d    = 1'b0;
      dropped_d = dropped_q | (write & busy_w);
      we        = 1'b0;
      waddr     = wr_idx;
      wdata     = writeData;
      case (state_q)
         S_IDLE: begin
            we = write;
            if (start) begin
               state_d = (start_address == 7'd0) ? S_LOAD : S_CLEAR;
               ptr_d   = '0;
            end
         end
         S_LOAD: begin
            if (init_valid) begin
               we    = 1'b1;
               waddr = ptr_q;
               wdata = init_data;
               ptr_d = ptr_q + ADDR_W'(1);
               if (last_ptr) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            we    = 1'b1;
            waddr = ptr_q;
            wdata = '0;
            ptr_d = ptr_q + ADDR_W'(1);
            if (last_ptr) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, pointer, flags and register array update
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         regs_q    <= '{default: '0};
         state_q   <= S_IDLE;
         ptr_q     <= '0;
         done_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         if (we) regs_q[waddr] <= wdata;
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         done_q    <= done_d;
         dropped_q <= dropped_d;
      end
   end

   // Forwarding only applies to a write that will actually commit
   always_comb begin
      fwd1      = (BYPASS != 0) && write && !busy_w && (wr_idx == src1);
      fwd2      = (BYPASS != 0) && write && !busy_w && (wr_idx == src2);
      readData1 = fwd1 ? writeData : regs_q[src1];
      readData2 = fwd2 ? writeData : regs_q[src2];
   end

   assign busy          = busy_w;
   assign init_ready    = (state_q == S_LOAD);
   assign init_done     = done_q;
   assign write_dropped = dropped_q;

endmodule
